// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, horizontal/vertical counters,
// active-low sync pulses, visible-region flag and a once-per-frame tick.
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int H_START = 144,
  parameter int H_END   = 784,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC  = 2,
  parameter int V_START = 35,
  parameter int V_END   = 515
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_LO = 10'(H_START);
  localparam logic [9:0] H_VIS_HI = 10'(H_END);
  localparam logic [9:0] V_VIS_LO = 10'(V_START);
  localparam logic [9:0] V_VIS_HI = 10'(V_END);

  logic [DIV_W-1:0] div;
  logic             h_wrap;
  logic             v_wrap;

  // Board-clock divider producing the pixel cadence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Pixel enable and wrap conditions decoded from registered state.
  always_comb begin
    pix_en = (div == DIV_LAST);
    h_wrap = (hCount == H_LAST);
    v_wrap = (vCount == V_LAST);
  end

  // Raster counters advance once per pixel; line end carries into vCount.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        hCount <= '0;
        vCount <= v_wrap ? '0 : vCount + 10'd1;
      end else begin
        hCount <= hCount + 10'd1;
      end
    end
  end

  // One-clk tick in the cycle following the end-of-frame wrap edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_en && h_wrap && v_wrap;
    end
  end

  // Sync and visible-region flags follow the counters with no added latency.
  always_comb begin
    hSync  = ~(hCount < H_SYNC_W);
    vSync  = ~(vCount < V_SYNC_W);
    bright = (hCount >= H_VIS_LO) && (hCount < H_VIS_HI) &&
             (vCount >= V_VIS_LO) && (vCount < V_VIS_HI);
  end

endmodule
